cv32e40p_trace_buffer: RTL and testbench
========================================

Name: cv32e40p_trace_buffer

Overview:
- Multi-channel retire/trace event capture buffer for the core's non-synthesised tracing path.
- Accepts up to NUM_CH parallel event streams and arbitrates them round-robin into one DEPTH-entry first-word-fall-through FIFO.
- Emits a single tagged output stream using a valid/ready handshake.
- Generalises single-channel, unbuffered trace taps: configurable width, depth and channel count; back-pressure or lossy mode; drop accounting.

Parameters:
- NUM_CH, 3, number of input event channels (1..8).
- DATA_W, 64, payload width per event.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- DROP_MODE, 0, 0 = stall (back-pressure channels); 1 = lossy (channels always ready, drops counted).
- CH_W, $clog2(NUM_CH) (min 1), derived; width of the channel tag.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous assertion, active-low.
- flush_i  in  1  synchronous clear of FIFO contents and drop counter.
- ch_valid_i  in  NUM_CH  per-channel event valid.
- ch_data_i  in  NUM_CH x DATA_W  per-channel payload.
- ch_ready_o  out  NUM_CH  per-channel accept.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  consumer accept.
- out_data_o  out  DATA_W  head payload.
- out_ch_o  out  CH_W  channel tag of head entry.
- level_o  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt_o  out  16  events dropped; saturating.
- overflow_o  out  1  sticky; set when any event is dropped.

Behaviour:
- Reset: FIFO empty; read/write pointers 0; round-robin pointer 0. Outputs: out_valid_o=0, out_data_o=0, out_ch_o=0, level_o=0, drop_cnt_o=0, overflow_o=0. ch_ready_o is 0 in stall mode and all-ones in lossy mode.
- Pop: occurs when out_valid_o & out_ready_i. The head is combinationally visible (FWFT).
- Push space: can_push = (level_o < DEPTH) | pop. A full FIFO therefore accepts a push in the same cycle it pops.
- Arbitration:
  - At most one push per cycle.
  - Grant goes to the first valid channel at or after rr_ptr, wrapping modulo NUM_CH.
  - On a push, rr_ptr <= grant+1 (mod NUM_CH); otherwise rr_ptr holds.
- Stall mode (DROP_MODE=0):
  - ch_ready_o[i] = can_push & (grant==i).
  - Channels not granted see ready low and must hold valid/data.
  - No drops occur; drop_cnt_o stays 0.
- Lossy mode (DROP_MODE=1):
  - ch_ready_o = all ones.
  - The granted event is pushed if can_push; otherwise it is dropped too.
  - Each valid non-pushed event that cycle counts as a drop.
  - drop_cnt_o += number dropped, saturating at 0xFFFF.
  - overflow_o <= 1 on any drop.
- level_o: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
- Pointers: wrap at DEPTH. out_data_o/out_ch_o are don't-care (held) when empty.
- flush_i:
  - Next cycle: level_o=0, out_valid_o=0, pointers 0, drop_cnt_o=0, overflow_o=0, rr_ptr=0.
  - Push and pop in the flush cycle are suppressed; ch_ready_o is forced 0 in stall mode.
- Reset asserted mid-operation discards all contents immediately (asynchronous).
- Latency: input accepted at edge N; visible on out_* after edge N (one cycle), including when empty.

Optional Feature:
- Macro: CV32E40P_TRACE_TIMESTAMP_EN.
- With the macro:
  - A 32-bit free-running cycle counter is added: reset 0, wraps at 2^32, cleared by flush_i.
  - Each entry stores the counter value at push time.
  - Extra port out_timestamp_o (out, 32) presents the head entry's timestamp.
- Without the macro: no counter, no timestamp storage, no out_timestamp_o port.

Test Plan:
- Single push/pop: stall mode, ch0 valid data 0x1234 for 1 cycle, out_ready_i=1 -> out_valid_o=1 next cycle, out_data_o=0x1234, out_ch_o=0, level_o returns to 0.
- Round-robin fairness: stall mode, all 3 channels valid continuously, out_ready_i=1 -> grant order 0,1,2,0,1,2; each channel accepted once per 3 cycles.
- Full + back-pressure: DEPTH=8, out_ready_i=0, ch1 valid for 10 cycles -> 8 accepted, ch_ready_o[1]=0 once level_o=8. Raising out_ready_i with ch1 still valid gives push+pop each cycle, level_o stays 8.
- Lossy drops: DROP_MODE=1, FIFO full, out_ready_i=0, 3 channels valid for 2 cycles -> drop_cnt_o=6, overflow_o=1, level_o=8.
- Saturation and flush: lossy mode with 0x10000 drops -> drop_cnt_o=0xFFFF. Pulse flush_i -> next cycle drop_cnt_o=0, overflow_o=0, level_o=0.
- Reset mid-operation: level_o=5, deassert rst_ni asynchronously between edges -> out_valid_o=0 and level_o=0 immediately; first push after release lands as head with out_ch_o correct.

Source files
------------

// File: rtl/cv32e40p_trace_buffer.sv
// cv32e40p_trace_buffer
// Multi-channel trace event capture buffer. NUM_CH event streams are
// arbitrated round-robin into a DEPTH-entry first-word-fall-through FIFO
// whose head is presented as a single tagged valid/ready stream.
// DROP_MODE=0 back-pressures the channels; DROP_MODE=1 keeps every channel
// ready and counts the events that could not be stored.
// Optional feature: define CV32E40P_TRACE_TIMESTAMP_EN to add a 32-bit cycle
// counter, a per-entry timestamp and the out_timestamp_o port.
module cv32e40p_trace_buffer #(
   parameter int NUM_CH    = 3,
   parameter int DATA_W    = 64,
   parameter int DEPTH     = 8,
   parameter int DROP_MODE = 0,
   parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic [NUM_CH-1:0]          ch_valid_i,
   input  logic [NUM_CH*DATA_W-1:0]   ch_data_i,
   output logic [NUM_CH-1:0]          ch_ready_o,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [DATA_W-1:0]          out_data_o,
   output logic [CH_W-1:0]            out_ch_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic [15:0]                drop_cnt_o,
   output logic                       overflow_o
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
   ,
   output logic [31:0]                out_timestamp_o
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   // Adds a per-cycle drop count to the counter, sticking at 0xFFFF.
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + 17'(b);
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   // FIFO storage
   logic [DATA_W-1:0] mem_data_q [DEPTH];
   logic [CH_W-1:0]   mem_ch_q   [DEPTH];

   // Control state
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [CH_W-1:0]  rr_q, rr_d;
   logic [15:0]      drop_q, drop_d;
   logic             ovf_q, ovf_d;

   // Arbitration and handshake terms
   logic              hi_vld, lo_vld, grant_vld;
   logic [CH_W-1:0]   hi_idx, lo_idx, grant, rr_next;
   logic              pop, can_push, push;
   logic [DATA_W-1:0] push_data;
   logic [3:0]        n_valid, n_drop;

`ifdef CV32E40P_TRACE_TIMESTAMP_EN
   logic [31:0] ts_q, ts_d;
   logic [31:0] mem_ts_q [DEPTH];
`endif

   // Round-robin search: lowest valid index at or above rr_q, else lowest valid overall.
   always_comb begin
      hi_vld = 1'b0;
      hi_idx = '0;
      lo_vld = 1'b0;
      lo_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_valid_i[i]) begin
            lo_vld = 1'b1;
            lo_idx = CH_W'(i);
            if (CH_W'(i) >= rr_q) begin
               hi_vld = 1'b1;
               hi_idx = CH_W'(i);
            end
         end
      end
   end

   assign grant_vld = lo_vld;
   assign grant     = hi_vld ? hi_idx : lo_idx;
   assign rr_next   = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign out_valid_o = (level_q != '0);
   assign pop         = out_valid_o & out_ready_i & ~flush_i;
   assign can_push    = (level_q < LVL_W'(DEPTH)) | pop;
   assign push        = grant_vld & can_push & ~flush_i;

   // Select the granted channel's payload and count the valid events this cycle.
   always_comb begin
      push_data = '0;
      n_valid   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant == CH_W'(i)) begin
            push_data = ch_data_i[i*DATA_W +: DATA_W];
         end
         n_valid = n_valid + 4'(ch_valid_i[i]);
      end
   end

   // Every valid event that did not make it into the FIFO is a drop (lossy only).
   assign n_drop = ((DROP_MODE != 0) && !flush_i) ? (n_valid - 4'(push)) : 4'd0;

   generate
      if (DROP_MODE != 0) begin : g_lossy
         assign ch_ready_o = '1;
      end else begin : g_stall
         // Only the channel being pushed this cycle sees ready.
         always_comb begin
            for (int i = 0; i < NUM_CH; i++) begin
               ch_ready_o[i] = push & (grant == CH_W'(i));
            end
         end
      end
   endgenerate

   // Next-state for pointers, occupancy, arbiter and drop accounting.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      rr_d     = rr_q;
      drop_d   = drop_q;
      ovf_d    = ovf_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         rr_d     = '0;
         drop_d   = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            rr_d     = rr_next;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
         if (n_drop != 4'd0) begin
            drop_d = sat_add16(drop_q, n_drop);
            ovf_d  = 1'b1;
         end
      end
   end

`ifdef CV32E40P_TRACE_TIMESTAMP_EN
   // Free-running cycle counter; restarts from zero on flush.
   always_comb begin
      ts_d = flush_i ? 32'd0 : ts_q + 32'd1;
   end

   // Cycle counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_d;
      end
   end
`endif

   // Control registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         rr_q     <= '0;
         drop_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         rr_q     <= rr_d;
         drop_q   <= drop_d;
         ovf_q    <= ovf_d;
      end
   end

   // Entry storage; cleared on reset so the empty head reads as zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int e = 0; e < DEPTH; e++) begin
            mem_data_q[e] <= '0;
            mem_ch_q[e]   <= '0;
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
            mem_ts_q[e]   <= '0;
`endif
         end
      end else if (push) begin
         mem_data_q[wr_ptr_q] <= push_data;
         mem_ch_q[wr_ptr_q]   <= grant;
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
         mem_ts_q[wr_ptr_q]   <= ts_q;
`endif
      end
   end

   assign out_data_o = mem_data_q[rd_ptr_q];
   assign out_ch_o   = mem_ch_q[rd_ptr_q];
   assign level_o    = level_q;
   assign drop_cnt_o = drop_q;
   assign overflow_o = ovf_q;
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
   assign out_timestamp_o = mem_ts_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_cv32e40p_trace_buffer.sv
// Bench for cv32e40p_trace_buffer: one stall-mode and one lossy-mode instance,
// driven side by side. A reference model predicts readiness, occupancy and
// drop accounting each cycle and queues expected entries; a monitor pops the
// queue whenever a head entry is consumed.
module tb_cv32e40p_trace_buffer;

   localparam int NUM_CH = 3;
   localparam int DATA_W = 64;
   localparam int DEPTH  = 8;
   localparam int CH_W   = 2;
   localparam int LVL_W  = 4;

   typedef struct packed {
      logic [CH_W-1:0]   ch;
      logic [DATA_W-1:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // index 0 = stall instance, index 1 = lossy instance
   logic [NUM_CH-1:0]        cv   [2];
   logic [NUM_CH*DATA_W-1:0] cd   [2];
   logic                     ordy [2];
   logic                     fl   [2];
   logic [NUM_CH-1:0]        s_v  [2];
   logic [NUM_CH*DATA_W-1:0] s_d  [2];
   logic                     s_r  [2];
   logic                     s_f  [2];

   logic [NUM_CH-1:0] rdy   [2];
   logic              ov    [2];
   logic [DATA_W-1:0] od    [2];
   logic [CH_W-1:0]   och   [2];
   logic [LVL_W-1:0]  lvo   [2];
   logic [15:0]       dc    [2];
   logic              ovf_o [2];
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
   logic [31:0]       ts_o  [2];
`endif

   cv32e40p_trace_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_MODE(0)) u_stall (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[0]), .ch_valid_i(cv[0]), .ch_data_i(cd[0]),
      .ch_ready_o(rdy[0]), .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .out_data_o(od[0]),
      .out_ch_o(och[0]), .level_o(lvo[0]), .drop_cnt_o(dc[0]), .overflow_o(ovf_o[0])
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
      , .out_timestamp_o(ts_o[0])
`endif
   );

   cv32e40p_trace_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_MODE(1)) u_lossy (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[1]), .ch_valid_i(cv[1]), .ch_data_i(cd[1]),
      .ch_ready_o(rdy[1]), .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .out_data_o(od[1]),
      .out_ch_o(och[1]), .level_o(lvo[1]), .drop_cnt_o(dc[1]), .overflow_o(ovf_o[1])
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
      , .out_timestamp_o(ts_o[1])
`endif
   );

   // reference model state
   int   m_lvl [2];
   int   m_rr  [2];
   int   m_drop[2];
   bit   m_ovf [2];
   ent_t q0[$];
   ent_t q1[$];
   bit   p_push[2];
   bit   p_pop [2];
   int   p_g   [2];
   int   p_nd  [2];
   logic [NUM_CH-1:0] acc[2];

   int n_chk  = 0;
   int n_fail = 0;

   function automatic string tag(input int m);
      return (m == 0) ? "stall" : "lossy";
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset(input int m);
      if (m == 0) q0.delete(); else q1.delete();
      m_lvl[m]  = 0;
      m_rr[m]   = 0;
      m_drop[m] = 0;
      m_ovf[m]  = 1'b0;
      acc[m]    = '0;
   endtask

   // Predict this cycle's behaviour from the rules and compare visible outputs.
   task automatic eval(input int m);
      bit pop, canp, push;
      int g, i, ndr;
      logic [NUM_CH-1:0] er;
      pop  = (m_lvl[m] > 0) && ordy[m] && !fl[m];
      canp = (m_lvl[m] < DEPTH) || pop;
      g = -1;
      for (int k = 0; k < NUM_CH; k++) begin
         i = (m_rr[m] + k) % NUM_CH;
         if (g < 0 && cv[m][i]) g = i;
      end
      push = (g >= 0) && canp && !fl[m];
      if (m == 1) er = '1;
      else if (push) er = NUM_CH'(1) << g;
      else er = '0;
      ndr = (m == 1 && !fl[m]) ? ($countones(cv[m]) - int'(push)) : 0;
      chk({tag(m), "_ch_ready"}, rdy[m], er);
      chk({tag(m), "_level"}, lvo[m], m_lvl[m]);
      chk({tag(m), "_out_valid"}, ov[m], m_lvl[m] > 0);
      chk({tag(m), "_drop_cnt"}, dc[m], m_drop[m]);
      chk({tag(m), "_overflow"}, ovf_o[m], m_ovf[m]);
      p_pop[m]  = pop;
      p_push[m] = push;
      p_g[m]    = g;
      p_nd[m]   = ndr;
      acc[m]    = push ? (NUM_CH'(1) << g) : '0;
   endtask

   // Advance the model past the coming clock edge.
   task automatic update(input int m);
      ent_t e;
      if (fl[m]) begin
         model_reset(m);
      end else begin
         if (p_push[m]) begin
            e.ch   = CH_W'(p_g[m]);
            e.data = cd[m][p_g[m]*DATA_W +: DATA_W];
            if (m == 0) q0.push_back(e); else q1.push_back(e);
            m_rr[m] = (p_g[m] + 1) % NUM_CH;
         end
         m_lvl[m] = m_lvl[m] + int'(p_push[m]) - int'(p_pop[m]);
         if (p_nd[m] > 0) begin
            m_drop[m] = (m_drop[m] + p_nd[m] > 65535) ? 65535 : m_drop[m] + p_nd[m];
            m_ovf[m]  = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         cv[m] = s_v[m]; cd[m] = s_d[m]; ordy[m] = s_r[m]; fl[m] = s_f[m];
      end
      #1;
      for (int m = 0; m < 2; m++) eval(m);
      #3;
      for (int m = 0; m < 2; m++) update(m);
   endtask

   // Stall-mode channels hold valid/data until accepted; free ones may raise new events.
   task automatic gen_stall(input logic [NUM_CH-1:0] allow, input int pct);
      for (int i = 0; i < NUM_CH; i++) begin
         if (!(cv[0][i] && !acc[0][i])) begin
            s_v[0][i] = allow[i] && ($urandom_range(99) < pct);
            s_d[0][i*DATA_W +: DATA_W] = {$urandom, $urandom};
         end
      end
   endtask

   task automatic gen_lossy(input logic [NUM_CH-1:0] allow, input int pct);
      for (int i = 0; i < NUM_CH; i++) begin
         s_v[1][i] = allow[i] && ($urandom_range(99) < pct);
         s_d[1][i*DATA_W +: DATA_W] = {$urandom, $urandom};
      end
   endtask

   // Scoreboard monitor: every consumed head must match the oldest expected entry.
   initial begin : monitor
      ent_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            for (int m = 0; m < 2; m++) begin
               if (ov[m] && ordy[m] && !fl[m]) begin
                  if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
                     n_chk++;
                     n_fail++;
                     $display("FAIL %s_unexpected_pop: got data 0x%0h, expected no entry", tag(m), od[m]);
                  end else begin
                     e = (m == 0) ? q0.pop_front() : q1.pop_front();
                     chk({tag(m), "_out_data"}, od[m], e.data);
                     chk({tag(m), "_out_ch"}, och[m], e.ch);
                  end
               end
            end
         end
      end
   end

   initial begin : stim
      int n;
      for (int m = 0; m < 2; m++) begin
         s_v[m] = '0; s_d[m] = '0; s_r[m] = 1'b0; s_f[m] = 1'b0;
         cv[m] = '0; cd[m] = '0; ordy[m] = 1'b0; fl[m] = 1'b0;
         model_reset(m);
      end
      #2 rst_n = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         chk({tag(m), "_rst_data"}, od[m], 0);
         chk({tag(m), "_rst_ch"}, och[m], 0);
         chk({tag(m), "_rst_valid"}, ov[m], 0);
         chk({tag(m), "_rst_level"}, lvo[m], 0);
      end
      chk("stall_rst_ready", rdy[0], 3'b000);
      chk("lossy_rst_ready", rdy[1], 3'b111);
      tick(); tick();
      rst_n = 1'b1;

      // single push/pop through the stall instance
      s_r[0] = 1'b1; s_r[1] = 1'b1;
      s_v[0] = 3'b001; s_d[0][DATA_W-1:0] = 64'h1234;
      tick();
      s_v[0] = '0;
      tick(); tick();

      // round-robin with every channel continuously valid
      for (int k = 0; k < 12; k++) begin gen_stall(3'b111, 100); tick(); end
      for (int k = 0; k < 4; k++) begin gen_stall(3'b000, 0); tick(); end

      // fill to DEPTH with back-pressure, then push+pop at full
      s_r[0] = 1'b0;
      for (int k = 0; k < 10; k++) begin gen_stall(3'b010, 100); tick(); end
      s_r[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin gen_stall(3'b010, 100); tick(); end
      for (int k = 0; k < 12; k++) begin gen_stall(3'b000, 0); tick(); end

      // lossy: fill, then two cycles of three valid channels
      s_r[1] = 1'b0;
      for (int k = 0; k < 8; k++) begin gen_lossy(3'b001, 100); tick(); end
      for (int k = 0; k < 2; k++) begin gen_lossy(3'b111, 100); tick(); end
      @(posedge clk); #2;
      chk("lossy_drop6", dc[1], 6);
      chk("lossy_ovf_set", ovf_o[1], 1);
      chk("lossy_full", lvo[1], 8);

      // saturate the drop counter, then flush
      for (int k = 0; k < 21850; k++) begin gen_lossy(3'b111, 100); tick(); end
      @(posedge clk); #2;
      chk("lossy_sat", dc[1], 16'hFFFF);
      s_f[1] = 1'b1;
      tick();
      s_f[1] = 1'b0; s_v[1] = '0;
      @(posedge clk); #2;
      chk("flush_drop", dc[1], 0);
      chk("flush_ovf", ovf_o[1], 0);
      chk("flush_level", lvo[1], 0);
      chk("flush_valid", ov[1], 0);

      // randomized traffic with occasional flushes
      for (int k = 0; k < 800; k++) begin
         gen_stall(3'b111, 40);
         gen_lossy(3'b111, 50);
         s_r[0] = ($urandom_range(99) < 60);
         s_r[1] = ($urandom_range(99) < 50);
         s_f[0] = ($urandom_range(39) == 0);
         s_f[1] = ($urandom_range(39) == 0);
         tick();
      end
      s_f[0] = 1'b0; s_f[1] = 1'b0;

      // reset mid-operation with five entries held in the stall instance
      s_r[0] = 1'b1; s_r[1] = 1'b1; s_v[1] = '0;
      for (int k = 0; k < 8; k++) begin gen_stall(3'b000, 0); tick(); end
      s_r[0] = 1'b0;
      n = 0;
      while (n < 20 && m_lvl[0] < 5) begin gen_stall(3'b001, 100); tick(); n++; end
      s_v[0] = '0;
      @(posedge clk); #2;
      chk("pre_reset_level", lvo[0], 5);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", ov[0], 0);
      chk("async_rst_level", lvo[0], 0);
      for (int m = 0; m < 2; m++) model_reset(m);
      tick();
      rst_n = 1'b1;
      s_r[0] = 1'b1;
      s_v[0] = 3'b100; s_d[0][2*DATA_W +: DATA_W] = 64'hCAFE_0002;
      tick();
      s_v[0] = '0;
      tick(); tick();

      // drain both instances
      s_r[0] = 1'b1; s_r[1] = 1'b1; s_v[1] = '0;
      for (int k = 0; k < 12; k++) begin gen_stall(3'b000, 0); tick(); end
      chk("stall_drained", q0.size(), 0);
      chk("lossy_drained", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
